// File: rtl/ser_word_rx.sv
// Serial-to-parallel frame receiver: start bit, WIDTH data bits, stop bit, valid/ack handshake.
// Define SER_WORD_RX_PARITY_EN to add an even-parity bit between data and stop, reported on perr.
module ser_word_rx #(
   parameter int WIDTH     = 32,
   parameter int MSB_FIRST = 1
) (
   input  logic             clk,
   input  logic             r,
   input  logic             si,
   input  logic             ack,
   output logic [WIDTH-1:0] q,
   output logic             valid,
   output logic             ovr,
   output logic             ferr,
`ifdef SER_WORD_RX_PARITY_EN
   output logic             perr,
`endif
   output logic             busy
);
   localparam int CW = $clog2(WIDTH);
   localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

   typedef enum logic [1:0] {IDLE, DATA, PARITY, STOP} state_t;

`ifdef SER_WORD_RX_PARITY_EN
   localparam state_t AFTER_DATA = PARITY;
`else
   localparam state_t AFTER_DATA = STOP;
`endif

   state_t           state_q, state_d;
   logic [CW-1:0]    cnt_q, cnt_d;
   logic [WIDTH-1:0] sh_q, sh_d;
   logic [WIDTH-1:0] word_q, word_d;
   logic             valid_q, valid_d;
   logic             ovr_q, ovr_d;
   logic             ferr_q, ferr_d;
   logic             good_stop;
`ifdef SER_WORD_RX_PARITY_EN
   logic             par_q, par_d;
   logic             pbad_q, pbad_d;
   logic             perr_q, perr_d;
`endif

   always_ff @(posedge clk or posedge r) begin
      if (r) state_q <= IDLE;
      else   state_q <= state_d;
   end

   always_comb begin
      state_d = state_q;
      unique case (state_q)
         IDLE:    if (!si) state_d = DATA;
         DATA:    if (cnt_q == LAST) state_d = AFTER_DATA;
         PARITY:  state_d = STOP;
         STOP:    state_d = IDLE;
         default: state_d = IDLE;
      endcase
   end

   always_comb begin
      cnt_d   = cnt_q;
      sh_d    = sh_q;
      word_d  = word_q;
      valid_d = valid_q;
      ovr_d   = ovr_q;
      ferr_d  = 1'b0;
`ifdef SER_WORD_RX_PARITY_EN
      par_d     = par_q;
      pbad_d    = pbad_q;
      perr_d    = 1'b0;
      good_stop = (state_q == STOP) && si && !pbad_q;
`else
      good_stop = (state_q == STOP) && si;
`endif
      if (ack && valid_q) begin
         valid_d = 1'b0;
         ovr_d   = 1'b0;
      end
      case (state_q)
         IDLE: begin
            if (!si) begin
               cnt_d = '0;
`ifdef SER_WORD_RX_PARITY_EN
               par_d  = 1'b0;
               pbad_d = 1'b0;
`endif
            end
         end
         DATA: begin
            sh_d = (MSB_FIRST != 0) ? {sh_q[WIDTH-2:0], si} : {si, sh_q[WIDTH-1:1]};
            // Counter saturates at LAST; the state change ends the data phase.
            if (cnt_q != LAST) cnt_d = cnt_q + CW'(1);
`ifdef SER_WORD_RX_PARITY_EN
            par_d = par_q ^ si;
`endif
         end
`ifdef SER_WORD_RX_PARITY_EN
         PARITY: pbad_d = par_q ^ si;
`endif
         STOP: begin
            ferr_d = !si;
`ifdef SER_WORD_RX_PARITY_EN
            perr_d = pbad_q;
`endif
         end
         default: ;
      endcase
      // A good stop wins over a same-edge ack, so valid stays set for the new word.
      if (good_stop) begin
         word_d  = sh_q;
         valid_d = 1'b1;
         if (valid_q && !ack) ovr_d = 1'b1;
      end
   end

   always_ff @(posedge clk or posedge r) begin
      if (r) begin
         cnt_q   <= '0;
         sh_q    <= '0;
         word_q  <= '0;
         valid_q <= 1'b0;
         ovr_q   <= 1'b0;
         ferr_q  <= 1'b0;
`ifdef SER_WORD_RX_PARITY_EN
         par_q   <= 1'b0;
         pbad_q  <= 1'b0;
         perr_q  <= 1'b0;
`endif
      end else begin
         cnt_q   <= cnt_d;
         sh_q    <= sh_d;
         word_q  <= word_d;
         valid_q <= valid_d;
         ovr_q   <= ovr_d;
         ferr_q  <= ferr_d;
`ifdef SER_WORD_RX_PARITY_EN
         par_q   <= par_d;
         pbad_q  <= pbad_d;
         perr_q  <= perr_d;
`endif
      end
   end

   always_comb begin
      q     = word_q;
      valid = valid_q;
      ovr   = ovr_q;
      ferr  = ferr_q;
      busy  = (state_q != IDLE);
`ifdef SER_WORD_RX_PARITY_EN
      perr  = perr_q;
`endif
   end
endmodule

// File: tb/tb_ser_word_rx.sv
// Directed bench for ser_word_rx: three instances (32-bit MSB-first, 8-bit MSB-first, 8-bit LSB-first)
// share the serial line; each test resets and checks the relevant instance.
module tb_ser_word_rx;
   logic        clk = 1'b0;
   logic        r   = 1'b0;
   logic        si  = 1'b1;
   logic        ack = 1'b0;

   logic [31:0] q32;
   logic        v32, o32, f32, b32;
   logic [7:0]  q8, q8r;
   logic        v8, o8, f8, b8;
   logic        v8r, o8r, f8r, b8r;
`ifdef SER_WORD_RX_PARITY_EN
   logic        p32, p8, p8r;
`endif

   int n_checks = 0;
   int n_pass   = 0;

   always #5 clk = ~clk;

   ser_word_rx #(.WIDTH(32), .MSB_FIRST(1)) u_rx32 (
      .clk(clk), .r(r), .si(si), .ack(ack), .q(q32), .valid(v32), .ovr(o32), .ferr(f32),
`ifdef SER_WORD_RX_PARITY_EN
      .perr(p32),
`endif
      .busy(b32));

   ser_word_rx #(.WIDTH(8), .MSB_FIRST(1)) u_rx8 (
      .clk(clk), .r(r), .si(si), .ack(ack), .q(q8), .valid(v8), .ovr(o8), .ferr(f8),
`ifdef SER_WORD_RX_PARITY_EN
      .perr(p8),
`endif
      .busy(b8));

   ser_word_rx #(.WIDTH(8), .MSB_FIRST(0)) u_rx8r (
      .clk(clk), .r(r), .si(si), .ack(ack), .q(q8r), .valid(v8r), .ovr(o8r), .ferr(f8r),
`ifdef SER_WORD_RX_PARITY_EN
      .perr(p8r),
`endif
      .busy(b8r));

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got === exp) n_pass++;
      else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic do_reset();
      #2 r = 1'b1;
      #3 r = 1'b0;
      si  = 1'b1;
      ack = 1'b0;
      tick();
      tick();
   endtask

   task automatic ack_pulse();
      ack = 1'b1;
      tick();
      ack = 1'b0;
   endtask

   // Returns just after the stop-bit edge with si back at idle.
   task automatic send_frame(input logic [31:0] d, input int w, input int msbf,
                             input logic stop, input logic par_bad, input logic ack_stop);
      logic par;
      par = 1'b0;
      si = 1'b0;
      tick();
      for (int i = 0; i < w; i++) begin
         si  = (msbf != 0) ? d[w-1-i] : d[i];
         par = par ^ d[i];
         tick();
      end
`ifdef SER_WORD_RX_PARITY_EN
      si = par ^ par_bad;
      tick();
`else
      if (par_bad && par) si = 1'b1;
`endif
      si = stop;
      if (ack_stop) ack = 1'b1;
      tick();
      si  = 1'b1;
      ack = 1'b0;
   endtask

   initial begin
      #1 r = 1'b1;
      #2;
      check("rst_q",     q32, 32'h0);
      check("rst_valid", {31'b0, v32}, 32'h0);
      check("rst_ovr",   {31'b0, o32}, 32'h0);
      check("rst_ferr",  {31'b0, f32}, 32'h0);
      check("rst_busy",  {31'b0, b32}, 32'h0);
      #9 r = 1'b0;
      tick();
      tick();

      // 32-bit good frame, MSB first
      send_frame(32'h5555_5555, 32, 1, 1'b1, 1'b0, 1'b0);
      check("w32_q",     q32, 32'h5555_5555);
      check("w32_valid", {31'b0, v32}, 32'h1);
      check("w32_busy",  {31'b0, b32}, 32'h0);
      check("w32_ovr",   {31'b0, o32}, 32'h0);
      ack_pulse();
      check("w32_ack",   {31'b0, v32}, 32'h0);

      // Bit ordering: line carries 1,0,1,1,0,0,0,0
      do_reset();
      send_frame(32'h0D, 8, 0, 1'b1, 1'b0, 1'b0);
      check("lsbf_q",     {24'b0, q8r}, 32'h0D);
      check("lsbf_valid", {31'b0, v8r}, 32'h1);
      check("msbf_q",     {24'b0, q8},  32'hB0);

      // Overrun, then ack collision on the second stop edge
      do_reset();
      send_frame(32'hA5, 8, 1, 1'b1, 1'b0, 1'b0);
      send_frame(32'h3C, 8, 1, 1'b1, 1'b0, 1'b0);
      check("ovr_q",     {24'b0, q8}, 32'h3C);
      check("ovr_valid", {31'b0, v8}, 32'h1);
      check("ovr_set",   {31'b0, o8}, 32'h1);
      ack_pulse();
      check("ovr_ack_valid", {31'b0, v8}, 32'h0);
      check("ovr_ack_ovr",   {31'b0, o8}, 32'h0);
      send_frame(32'hA5, 8, 1, 1'b1, 1'b0, 1'b0);
      send_frame(32'h3C, 8, 1, 1'b1, 1'b0, 1'b1);
      check("coll_ovr",   {31'b0, o8}, 32'h0);
      check("coll_valid", {31'b0, v8}, 32'h1);
      check("coll_q",     {24'b0, q8}, 32'h3C);

      // Framing error keeps the previous word
      do_reset();
      send_frame(32'h5A, 8, 1, 1'b1, 1'b0, 1'b0);
      ack_pulse();
      send_frame(32'hFF, 8, 1, 1'b0, 1'b0, 1'b0);
      check("ferr_pulse", {31'b0, f8}, 32'h1);
      check("ferr_valid", {31'b0, v8}, 32'h0);
      check("ferr_q",     {24'b0, q8}, 32'h5A);
      check("ferr_busy",  {31'b0, b8}, 32'h0);
      tick();
      check("ferr_clear", {31'b0, f8}, 32'h0);
      send_frame(32'h01, 8, 1, 1'b1, 1'b0, 1'b0);
      check("after_ferr_q",     {24'b0, q8}, 32'h01);
      check("after_ferr_valid", {31'b0, v8}, 32'h1);

      // Asynchronous reset in the middle of a frame
      do_reset();
      send_frame(32'h77, 8, 1, 1'b1, 1'b0, 1'b0);
      si = 1'b0;
      tick();
      for (int i = 0; i < 4; i++) begin
         si = 1'b1;
         tick();
      end
      #3 r = 1'b1;
      #1;
      check("midrst_q",     {24'b0, q8}, 32'h0);
      check("midrst_valid", {31'b0, v8}, 32'h0);
      check("midrst_busy",  {31'b0, b8}, 32'h0);
      check("midrst_ovr",   {31'b0, o8}, 32'h0);
      #2 r = 1'b0;
      si = 1'b1;
      tick();
      tick();
      send_frame(32'h81, 8, 1, 1'b1, 1'b0, 1'b0);
      check("post_rst_q",     {24'b0, q8}, 32'h81);
      check("post_rst_valid", {31'b0, v8}, 32'h1);

`ifdef SER_WORD_RX_PARITY_EN
      do_reset();
      send_frame(32'h03, 8, 1, 1'b1, 1'b0, 1'b0);
      check("par_ok_valid", {31'b0, v8}, 32'h1);
      check("par_ok_q",     {24'b0, q8}, 32'h03);
      check("par_ok_perr",  {31'b0, p8}, 32'h0);
      ack_pulse();
      send_frame(32'h03, 8, 1, 1'b1, 1'b1, 1'b0);
      check("par_bad_perr",  {31'b0, p8}, 32'h1);
      check("par_bad_valid", {31'b0, v8}, 32'h0);
      check("par_bad_ferr",  {31'b0, f8}, 32'h0);
      check("par_bad_q",     {24'b0, q8}, 32'h03);
      tick();
      check("par_bad_clear", {31'b0, p8}, 32'h0);
`endif

      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end
endmodule
